// File: rtl/modctl_seq_p_if.sv
// Command-side handshake between the command interface and the modular add/sub controller.
interface modctl_seq_p_if;
    logic       start;
    logic [1:0] op;
    logic       busy;
    logic       done;
    logic       result_rdy;
    logic       result_flag;

    modport master (output start, op, input busy, done, result_rdy, result_flag);
    modport slave  (input start, op, output busy, done, result_rdy, result_flag);
endinterface

// File: rtl/modctl_seq_p.sv
// Digit-serial controller for the modular add/sub/double datapath (A, B, P, S0, S1, carry DFF).
// Optional op_err pulse for the reserved opcode is enabled with `define MODCTL_OP_ERR_EN.
module modctl_seq_p #(
    parameter int NDIG = 16,
    parameter int CW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    modctl_seq_p_if.slave cmd,
    input  logic          sign_a_b,
    input  logic          sign_a_b_p,
    output logic [CW-1:0] count,
    output logic          rega_we,
    output logic          regb_we,
    output logic          regp_we,
    output logic          regs0_we,
    output logic          regs1_we,
    output logic          dff1_we,
    output logic          rega_cyc,
    output logic          regb_cyc,
    output logic          regp_cyc,
    output logic          regs0_cyc,
    output logic          regs1_cyc,
    output logic          mux0_sel,
    output logic          mux1_sel,
    output logic          opb_sel,
    output logic          carry_sel,
    output logic          add_sub,
`ifdef MODCTL_OP_ERR_EN
    output logic          op_err,
`endif
    output logic          count_en
);

    typedef enum logic [2:0] {IDLE, P1_ADD, P1_SUB, P2_SUBP, P2_ADDP} state_t;

    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t     state;
    logic [1:0] mode;
    logic       done_r;
    logic       rdy_r;
    logic       flag_r;
    logic       active;
    logic       pass1;
    logic       pass2;
    logic       dbl;
    logic       last;

    assign active = (state != IDLE);
    assign pass1  = (state == P1_ADD) || (state == P1_SUB);
    assign pass2  = (state == P2_SUBP) || (state == P2_ADDP);
    assign dbl    = (mode == 2'b10);
    assign last   = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode   <= 2'b00;
            count  <= '0;
            done_r <= 1'b0;
            rdy_r  <= 1'b0;
            flag_r <= 1'b0;
`ifdef MODCTL_OP_ERR_EN
            op_err <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
`ifdef MODCTL_OP_ERR_EN
            op_err <= 1'b0;
`endif
            // Counter wraps at every pass boundary, so each new pass starts at digit 0
            if (active) count <= last ? '0 : count + CW'(1);
            else        count <= '0;

            case (state)
                IDLE: begin
                    if (cmd.start) begin
                        case (cmd.op)
                            2'b00, 2'b10: begin
                                state <= P1_ADD;
                                mode  <= cmd.op;
                                rdy_r <= 1'b0;
                            end
                            2'b01: begin
                                state <= P1_SUB;
                                mode  <= cmd.op;
                                rdy_r <= 1'b0;
                            end
                            default: begin
`ifdef MODCTL_OP_ERR_EN
                                op_err <= 1'b1;
`endif
                            end
                        endcase
                    end
                end
                P1_ADD: if (last) state <= P2_SUBP;
                P1_SUB: begin
                    if (last) begin
                        if (sign_a_b) begin
                            state <= P2_ADDP;
                        end else begin
                            // A-B did not borrow: S0 already holds the result
                            state  <= IDLE;
                            done_r <= 1'b1;
                            rdy_r  <= 1'b1;
                            flag_r <= 1'b0;
                        end
                    end
                end
                P2_SUBP: begin
                    if (last) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                        rdy_r  <= 1'b1;
                        flag_r <= ~sign_a_b_p;
                    end
                end
                P2_ADDP: begin
                    if (last) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                        rdy_r  <= 1'b1;
                        flag_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd.busy        = active;
    assign cmd.done        = done_r;
    assign cmd.result_rdy  = rdy_r;
    assign cmd.result_flag = flag_r;

    // In doubling the B register is frozen and A feeds both adder inputs
    assign rega_we   = pass1;
    assign rega_cyc  = pass1;
    assign regb_we   = pass1 && !dbl;
    assign regb_cyc  = pass1 && !dbl;
    assign opb_sel   = pass1 && dbl;
    assign regp_we   = pass2;
    assign regp_cyc  = pass2;
    assign regs1_we  = pass2;
    assign mux0_sel  = pass2;
    assign mux1_sel  = pass2;
    assign regs0_cyc = pass2;
    assign regs1_cyc = 1'b0;
    assign regs0_we  = active;
    assign count_en  = active;
    assign carry_sel = active && (count == '0);
    assign add_sub   = (state == P1_SUB) || (state == P2_SUBP);
    assign dff1_we   = (state == P1_ADD) && last;

endmodule
